// File: rtl/chip_test_ctrl.sv
// Chip tester sequencer: launches one of NUM_CHIPS attached testers, waits for
// its Done (or a timeout), strobes its result display and latches the verdict.
module chip_test_ctrl #(
  parameter int NUM_CHIPS      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [2:0]           Chip_Sel,
  input  logic [NUM_CHIPS-1:0] Done_Chip,
  input  logic [NUM_CHIPS-1:0] RSLT_Chip,
  output logic [NUM_CHIPS-1:0] Run_Chip,
  output logic [NUM_CHIPS-1:0] DISP_Chip,
  output logic [2:0]           Sel_Lat,
  output logic                 Busy,
  output logic                 Done,
  output logic                 RSLT,
  output logic                 Timeout,
  output logic                 Err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    TEST   = 3'd2,
    DISP   = 3'd3,
    SAMPLE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic        run_q;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  sel_n;
  logic        rslt_n, tmo_n, err_n;

  logic                 start;
  logic                 sel_valid;
  logic [NUM_CHIPS-1:0] sel_onehot;
  logic                 done_sel;
  logic                 rslt_sel;

  assign start      = Run & ~run_q;
  assign sel_valid  = int'(Chip_Sel) < NUM_CHIPS;
  // Mask-and-reduce instead of indexing, so an out-of-range Sel_Lat reads as 0.
  assign sel_onehot = NUM_CHIPS'(1) << Sel_Lat;
  assign done_sel   = |(Done_Chip & sel_onehot);
  assign rslt_sel   = |(RSLT_Chip & sel_onehot);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      run_q   <= 1'b0;
      cnt     <= '0;
      Sel_Lat <= '0;
      RSLT    <= 1'b0;
      Timeout <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state   <= state_n;
      run_q   <= Run;
      cnt     <= cnt_n;
      Sel_Lat <= sel_n;
      RSLT    <= rslt_n;
      Timeout <= tmo_n;
      Err     <= err_n;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = Sel_Lat;
    rslt_n    = RSLT;
    tmo_n     = Timeout;
    err_n     = Err;
    Run_Chip  = '0;
    DISP_Chip = '0;
    Busy      = 1'b0;
    Done      = 1'b0;

    unique case (state)
      IDLE, HOLD: begin
        Done = (state == HOLD);
        if (start) begin
          rslt_n = 1'b0;
          tmo_n  = 1'b0;
          err_n  = 1'b0;
          sel_n  = Chip_Sel;
          if (sel_valid) begin
            cnt_n   = '0;
            state_n = LAUNCH;
          end else begin
            err_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
      // All Run lines low for one cycle so a tester left running restarts.
      LAUNCH: begin
        Busy    = 1'b1;
        state_n = TEST;
      end
      TEST: begin
        Busy     = 1'b1;
        Run_Chip = sel_onehot;
        cnt_n    = cnt + 16'd1;
        if (done_sel) begin
          state_n = DISP;
        end else if (cnt == CNT_LAST) begin
          tmo_n   = 1'b1;
          rslt_n  = 1'b0;
          state_n = HOLD;
        end
      end
      DISP: begin
        Busy      = 1'b1;
        Run_Chip  = sel_onehot;
        DISP_Chip = sel_onehot;
        state_n   = SAMPLE;
      end
      SAMPLE: begin
        Busy      = 1'b1;
        DISP_Chip = sel_onehot;
        rslt_n    = rslt_sel;
        state_n   = HOLD;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip_test_ctrl.sv
// Directed bench for chip_test_ctrl: pass, timeout, invalid select, isolation,
// restart and asynchronous reset, across three parameterisations.
module tb_chip_test_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic [2:0] Chip_Sel;

  // main instance: defaults
  logic [7:0] m_done_chip, m_rslt_chip, m_run_chip, m_disp_chip;
  logic [2:0] m_sel_lat;
  logic       m_busy, m_done, m_rslt, m_timeout, m_err;
  // timeout instance: TIMEOUT_CYCLES = 16
  logic [7:0] t_done_chip, t_rslt_chip, t_run_chip, t_disp_chip;
  logic [2:0] t_sel_lat;
  logic       t_busy, t_done, t_rslt, t_timeout, t_err;
  // invalid-select instance: NUM_CHIPS = 5
  logic [4:0] e_done_chip, e_rslt_chip, e_run_chip, e_disp_chip;
  logic [2:0] e_sel_lat;
  logic       e_busy, e_done, e_rslt, e_timeout, e_err;

  int n_compared = 0;
  int n_mismatched = 0;

  chip_test_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Chip_Sel(Chip_Sel),
    .Done_Chip(m_done_chip), .RSLT_Chip(m_rslt_chip),
    .Run_Chip(m_run_chip), .DISP_Chip(m_disp_chip), .Sel_Lat(m_sel_lat),
    .Busy(m_busy), .Done(m_done), .RSLT(m_rslt), .Timeout(m_timeout), .Err(m_err)
  );

  chip_test_ctrl #(.NUM_CHIPS(8), .TIMEOUT_CYCLES(16)) dut_t (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Chip_Sel(Chip_Sel),
    .Done_Chip(t_done_chip), .RSLT_Chip(t_rslt_chip),
    .Run_Chip(t_run_chip), .DISP_Chip(t_disp_chip), .Sel_Lat(t_sel_lat),
    .Busy(t_busy), .Done(t_done), .RSLT(t_rslt), .Timeout(t_timeout), .Err(t_err)
  );

  chip_test_ctrl #(.NUM_CHIPS(5), .TIMEOUT_CYCLES(65535)) dut_e (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Chip_Sel(Chip_Sel),
    .Done_Chip(e_done_chip), .RSLT_Chip(e_rslt_chip),
    .Run_Chip(e_run_chip), .DISP_Chip(e_disp_chip), .Sel_Lat(e_sel_lat),
    .Busy(e_busy), .Done(e_done), .RSLT(e_rslt), .Timeout(e_timeout), .Err(e_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Run         = 1'b0;
    Chip_Sel    = 3'd0;
    m_done_chip = '0; m_rslt_chip = '0;
    t_done_chip = '0; t_rslt_chip = '0;
    e_done_chip = '0; e_rslt_chip = '0;
    Reset = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_busy",    32'(m_busy), 0);
    check("rst_done",    32'(m_done), 0);
    check("rst_run",     32'(m_run_chip), 0);
    check("rst_sel_lat", 32'(m_sel_lat), 0);
    check("rst_flags",   32'({m_rslt, m_timeout, m_err}), 0);

    // ---------------- pass path, Run held high ----------------
    Chip_Sel = 3'd3; Run = 1'b1;
    tick();                                   // -> LAUNCH
    Chip_Sel = 3'd0;                          // latched value must persist
    check("pass_launch_busy", 32'(m_busy), 1);
    check("pass_launch_run",  32'(m_run_chip), 0);
    tick();                                   // -> TEST
    check("pass_test_run",    32'(m_run_chip), 32'h08);
    check("pass_sel_lat",     32'(m_sel_lat), 3);
    repeat (19) tick();
    check("pass_test_nodone", 32'(m_done), 0);
    m_done_chip = 8'h08; m_rslt_chip = 8'h08;
    tick();                                   // -> DISP
    check("pass_disp_disp",   32'(m_disp_chip), 32'h08);
    check("pass_disp_run",    32'(m_run_chip), 32'h08);
    tick();                                   // -> SAMPLE
    check("pass_smp_disp",    32'(m_disp_chip), 32'h08);
    check("pass_smp_run",     32'(m_run_chip), 0);
    check("pass_smp_done",    32'(m_done), 0);
    tick();                                   // -> HOLD
    m_done_chip = '0; m_rslt_chip = '0;
    check("pass_hold_done",   32'(m_done), 1);
    check("pass_hold_rslt",   32'(m_rslt), 1);
    check("pass_hold_tmo",    32'({m_timeout, m_err}), 0);
    check("pass_hold_busy",   32'(m_busy), 0);
    check("pass_hold_outs",   32'({m_run_chip, m_disp_chip}), 0);

    // ---------------- restart ----------------
    repeat (3) tick();
    check("rs_held_done",     32'(m_done), 1);
    check("rs_held_busy",     32'(m_busy), 0);
    check("rs_held_rslt",     32'(m_rslt), 1);
    Run = 1'b0;
    tick();
    Chip_Sel = 3'd4; Run = 1'b1;
    tick();                                   // HOLD -> LAUNCH
    check("rs_launch_done",   32'(m_done), 0);
    check("rs_launch_rslt",   32'(m_rslt), 0);
    check("rs_launch_busy",   32'(m_busy), 1);
    check("rs_sel_lat",       32'(m_sel_lat), 4);
    tick();
    check("rs_test_run",      32'(m_run_chip), 32'h10);
    m_done_chip = 8'h10; m_rslt_chip = 8'hEF;  // tester 4 fails, others pass
    repeat (3) tick();
    check("rs_hold_done",     32'(m_done), 1);
    check("rs_hold_rslt",     32'(m_rslt), 0);

    // ---------------- isolation ----------------
    do_reset();
    Chip_Sel = 3'd2; Run = 1'b1;
    tick(); tick();                           // LAUNCH, TEST
    m_done_chip = 8'h20; m_rslt_chip = 8'hFF;
    tick();
    m_done_chip = '0;
    check("iso_stay_run",     32'(m_run_chip), 32'h04);
    check("iso_stay_disp",    32'(m_disp_chip), 0);
    check("iso_stay_done",    32'(m_done), 0);
    tick();
    check("iso_stay2_busy",   32'(m_busy), 1);
    m_done_chip = 8'h04; m_rslt_chip = 8'hFB;  // only tester 2 fails
    repeat (3) tick();
    check("iso_hold_done",    32'(m_done), 1);
    check("iso_hold_rslt",    32'(m_rslt), 0);

    // ---------------- timeout (TIMEOUT_CYCLES=16) ----------------
    do_reset();
    Chip_Sel = 3'd1; Run = 1'b1;
    tick();                                   // LAUNCH
    check("tmo_launch_run",   32'(t_run_chip), 0);
    repeat (16) tick();                       // 16th TEST cycle still running
    check("tmo_last_busy",    32'(t_busy), 1);
    check("tmo_last_run",     32'(t_run_chip), 32'h02);
    tick();                                   // -> HOLD
    check("tmo_hold_done",    32'(t_done), 1);
    check("tmo_hold_tmo",     32'(t_timeout), 1);
    check("tmo_hold_rslt",    32'(t_rslt), 0);
    check("tmo_hold_err",     32'(t_err), 0);
    check("tmo_hold_run",     32'(t_run_chip), 0);

    // ---------------- invalid select (NUM_CHIPS=5) ----------------
    do_reset();
    Chip_Sel = 3'd6; Run = 1'b1;
    tick();
    check("inv_done",         32'(e_done), 1);
    check("inv_err",          32'(e_err), 1);
    check("inv_rslt_tmo",     32'({e_rslt, e_timeout}), 0);
    check("inv_sel_lat",      32'(e_sel_lat), 6);
    check("inv_busy",         32'(e_busy), 0);
    tick();
    check("inv_run",          32'(e_run_chip), 0);
    Run = 1'b0; tick();
    Chip_Sel = 3'd5; Run = 1'b1; tick();      // first out-of-range value
    check("inv5_err",         32'(e_err), 1);
    check("inv5_busy",        32'(e_busy), 0);
    Run = 1'b0; tick();
    Chip_Sel = 3'd4; Run = 1'b1; tick();      // last valid value
    check("val4_busy",        32'(e_busy), 1);
    check("val4_flags",       32'({e_done, e_err}), 0);

    // ---------------- reset mid-test ----------------
    do_reset();
    Chip_Sel = 3'd0; Run = 1'b1;
    tick(); tick(); tick();                   // LAUNCH, TEST, TEST
    check("rmid_run_before",  32'(m_run_chip), 32'h01);
    #2 Reset = 1'b0;
    #1;
    check("rmid_run_async",   32'(m_run_chip), 0);
    check("rmid_busy_async",  32'(m_busy), 0);
    check("rmid_outs_async",  32'({m_done, m_rslt, m_timeout, m_err, m_sel_lat}), 0);
    Run = 1'b0;
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    check("rmid_idle_busy",   32'(m_busy), 0);
    check("rmid_idle_run",    32'(m_run_chip), 0);
    Run = 1'b1; tick();
    check("rmid_new_start",   32'(m_busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
